// File: rtl/mag_com_pkg.sv
// mag_com_pkg: state encoding and result codes shared by the sequential comparator
package mag_com_pkg;
   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
   localparam logic [1:0] F_EQ = 2'b00;
   localparam logic [1:0] F_LT = 2'b01;
   localparam logic [1:0] F_GT = 2'b10;
endpackage

// File: rtl/mag_com_digit.sv
// mag_com_digit: combinational unsigned compare of one DIGIT-bit slice
module mag_com_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             gt
);
   assign lt = a < b;
   assign gt = a > b;
endmodule

// File: rtl/mag_com_seq.sv
// mag_com_seq: digit-serial MSB-first magnitude comparator with early termination
module mag_com_seq
   import mag_com_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [1:0]       f
);
   localparam int N = WIDTH / DIGIT;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   state_t state, nxt;
   logic [WIDTH-1:0] ra, rb, ea, eb;
   logic [DIGIT-1:0] sa, sb;
   logic [IW-1:0] idx;
   logic rs, lt, gt, go, last;
   // flipping the sign bit maps two's-complement order onto unsigned order
   assign ea = ra ^ {rs, {(WIDTH-1){1'b0}}};
   assign eb = rb ^ {rs, {(WIDTH-1){1'b0}}};
   assign sa = DIGIT'(ea >> (DIGIT * int'(LAST - idx)));
   assign sb = DIGIT'(eb >> (DIGIT * int'(LAST - idx)));
   mag_com_digit #(.DIGIT(DIGIT)) u_digit (.a(sa), .b(sb), .lt(lt), .gt(gt));
   always_comb begin
      last = idx == LAST;
      go = start && state != CMP;
      nxt = go ? CMP : state == CMP ? ((lt || gt || last) ? DONE : CMP) : IDLE;
      busy = state == CMP;
      done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ra <= '0;
         rb <= '0;
         rs <= 1'b0;
         idx <= '0;
         f <= F_EQ;
      end else if (go) begin
         ra <= a;
         rb <= b;
         rs <= sgn;
         idx <= '0;
      end else if (state == CMP) begin
         if (lt || gt || last) f <= gt ? F_GT : lt ? F_LT : F_EQ;
         else idx <= idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_mag_com_seq.sv
// tb_mag_com_seq: scoreboard bench for an 8x1 and a 16x4 comparator instance
module tb_mag_com_seq;
   typedef struct { logic [1:0] f; int cyc; } exp_t;
   logic clk = 0, rst = 1;
   logic start0 = 0, sgn0 = 0, start1 = 0, sgn1 = 0;
   logic [7:0] a0 = 0, b0 = 0;
   logic [15:0] a1 = 0, b1 = 0;
   logic busy0, done0, busy1, done1;
   logic [1:0] f0, f1;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   int free[2] = '{0, 0};
   int blo[2] = '{1, 1};
   int bhi[2] = '{0, 0};
   logic [1:0] hf[2] = '{2'b00, 2'b00};
   bit fin = 0;
   exp_t q0[$], q1[$];

   mag_com_seq #(.WIDTH(8), .DIGIT(1)) dut0 (.clk(clk), .rst(rst), .start(start0), .sgn(sgn0),
      .a(a0), .b(b0), .busy(busy0), .done(done0), .f(f0));
   mag_com_seq #(.WIDTH(16), .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .start(start1), .sgn(sgn1),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .f(f1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // result from integer values; latency from position of the most significant differing digit
   function automatic void model(input logic [15:0] x, input logic [15:0] y, input bit s,
                                 input int w, input int d, output logic [1:0] ef, output int lat);
      int va, vb, m;
      m = (1 << w) - 1;
      va = int'(x) & m;
      vb = int'(y) & m;
      lat = w / d + 1;
      for (int i = 0; i < w / d; i++)
         if (((va >> (i * d)) % (1 << d)) != ((vb >> (i * d)) % (1 << d))) lat = w / d - i + 1;
      if (s && va >= (1 << (w - 1))) va -= 1 << w;
      if (s && vb >= (1 << (w - 1))) vb -= 1 << w;
      ef = va < vb ? 2'b01 : va > vb ? 2'b10 : 2'b00;
   endfunction

   task automatic step(input int u, input bit st, input bit r, input logic [15:0] x,
                       input logic [15:0] y, input bit s);
      int c, lat;
      logic [1:0] ef;
      exp_t e;
      @(negedge clk);
      c = cyc;
      rst = r;
      start0 = st && u == 0;
      start1 = st && u == 1;
      a0 = x[7:0];
      b0 = y[7:0];
      sgn0 = s;
      a1 = x;
      b1 = y;
      sgn1 = s;
      if (r) begin
         q0.delete();
         q1.delete();
         for (int i = 0; i < 2; i++) begin
            free[i] = c + 1;
            if (bhi[i] > c) bhi[i] = c;
         end
      end else if (st && c >= free[u]) begin
         model(x, y, s, u ? 16 : 8, u ? 4 : 1, ef, lat);
         e.f = ef;
         e.cyc = c + lat;
         if (u == 1) q1.push_back(e);
         else q0.push_back(e);
         free[u] = c + lat;
         blo[u] = c + 1;
         bhi[u] = c + lat - 1;
      end
   endtask

   task automatic idle(input int u);
      step(u, 0, 0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
   endtask

   task automatic rnd(input int u, input int w);
      logic [15:0] x, y;
      int k;
      x = 16'($urandom);
      k = $urandom_range(0, 3);
      if (k == 0) y = x;
      else if (k == 1) y = x ^ (16'(1) << $urandom_range(0, w - 1));
      else y = 16'($urandom);
      step(u, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0, x, y, 1'($urandom_range(0, 1)));
   endtask

   task automatic chk(input int u, input string nm, input int act, input int ex);
      n_cmp++;
      if (act != ex) begin
         n_bad++;
         $display("FAIL dut%0d %s at cycle %0d: got %0d, want %0d", u, nm, cyc, act, ex);
      end
   endtask

   task automatic mon(input int u);
      logic d, bz;
      logic [1:0] fo;
      exp_t e;
      bit have;
      d = u == 1 ? done1 : done0;
      bz = u == 1 ? busy1 : busy0;
      fo = u == 1 ? f1 : f0;
      have = u == 1 ? q1.size() > 0 : q0.size() > 0;
      if (have) begin
         if (u == 1) e = q1[0];
         else e = q0[0];
      end
      if (rst) hf[u] = 2'b00;
      chk(u, "busy", int'(bz), int'(!rst && cyc >= blo[u] && cyc <= bhi[u]));
      if (have && (d || cyc >= e.cyc)) begin
         chk(u, "done_cycle", d ? cyc : -1, e.cyc);
         hf[u] = e.f;
         if (u == 1) void'(q1.pop_front());
         else void'(q0.pop_front());
      end else if (!have) chk(u, "unexpected_done", int'(d), 0);
      chk(u, "f", int'(fo), int'(hf[u]));
   endtask

   always @(posedge clk) begin
      #1;
      mon(0);
      mon(1);
      if (fin) begin
         chk(0, "drain", q0.size(), 0);
         chk(1, "drain", q1.size(), 0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: summary not reached by time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 16'h80, 16'h02, 0);
      repeat (3) idle(0);
      step(0, 1, 0, 16'h80, 16'h02, 1);
      repeat (3) idle(0);
      step(0, 1, 0, 16'h5A, 16'h5A, 0);
      repeat (9) idle(0);
      step(0, 1, 0, 16'h13, 16'h12, 0);
      repeat (9) idle(0);
      step(0, 1, 0, 16'h12, 16'h13, 0);
      repeat (9) idle(0);
      step(0, 1, 0, 16'h01, 16'h02, 0);
      repeat (2) idle(0);
      step(0, 1, 0, 16'hFF, 16'h02, 0);
      repeat (8) idle(0);
      step(0, 1, 0, 16'h00, 16'h00, 0);
      repeat (3) idle(0);
      step(0, 0, 1, 0, 0, 0);
      idle(0);
      step(0, 1, 0, 16'h37, 16'h35, 1);
      repeat (9) idle(0);
      step(0, 1, 1, 16'h01, 16'h00, 0);
      repeat (3) idle(0);
      repeat (1500) rnd(0, 8);
      repeat (12) idle(0);
      step(1, 1, 0, 16'h1234, 16'h1235, 0);
      repeat (4) idle(1);
      step(1, 1, 0, 16'h8000, 16'h7FFF, 1);
      repeat (3) idle(1);
      repeat (1500) rnd(1, 16);
      repeat (12) idle(1);
      fin = 1;
   end
endmodule

// File: doc/mag_com_seq.md
MAG_COM_SEQ -- requirements
Module: mag_com_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (>= 2).
REQ-002 SHALL have parameter DIGIT, default 1, bits compared per cycle; WIDTH SHALL be a multiple of DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a comparison.
REQ-006 SHALL have port sgn  input  1  mode: 1 = two's-complement, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  operand A, sampled with start.
REQ-008 SHALL have port b  input  WIDTH  operand B, sampled with start.
REQ-009 SHALL have port busy  output  1  comparison in progress; start ignored while high.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port f  output  2  result: f[0] = A<B, f[1] = A>B, 00 = equal; 11 never produced.

Function
REQ-012 SHALL implement states IDLE, CMP, DONE.
REQ-013 IDLE: start=1 at edge k SHALL latch a, b, sgn, clear digit index to 0 (most significant digit), enter CMP; busy=1 from edge k.
REQ-014 CMP: each cycle SHALL compare one DIGIT-bit slice, MSB-first, of latched A and B.
REQ-015 Signed mode SHALL invert the top bit of both operands before comparison; unsigned mode SHALL compare raw bits.
REQ-016 CMP SHALL terminate early: first slice where A!=B SHALL fix f (lt or gt) and move to DONE on the next edge.
REQ-017 CMP with all slices equal SHALL set f=00 and move to DONE after the last slice (index WIDTH/DIGIT-1).
REQ-018 Latency: slice i examined in cycle k+i; done=1 in cycle k+i+1; maximum start-to-done latency WIDTH/DIGIT+1 cycles, minimum 2.
REQ-019 DONE: done=1, busy=0 for exactly one cycle, then IDLE; start in DONE cycle SHALL be accepted as in IDLE (back-to-back).
REQ-020 f SHALL update only on entry to DONE and hold its value until the next result or reset.
REQ-021 start while in CMP SHALL be ignored; latched operands SHALL not change.
REQ-022 Changes on a, b, sgn while busy SHALL not affect the running comparison.
REQ-023 Digit index SHALL not wrap; it SHALL stop at the last slice.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, busy=0, done=0, f=00, index=0, operand registers 0.
REQ-025 rst mid-comparison SHALL abort it with no done pulse; rst SHALL take priority over start in the same cycle.

Structure
REQ-026 Package mag_com_pkg SHALL hold the state enum and result constants (F_EQ=00, F_LT=01, F_GT=10).
REQ-027 One sub-module mag_com_digit SHALL be used: combinational DIGIT-bit slice compare producing lt, gt.
REQ-028 Datapath SHALL be a single latched operand pair plus index counter; no shift of full-width operands is required.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-029 a=0x80, b=0x02, sgn=0, start -> f=10, done 2 cycles after start edge.
REQ-030 a=0x80, b=0x02, sgn=1 -> f=01 (-128 < 2), done 2 cycles after start.
REQ-031 a=b=0x5A -> f=00, done 9 cycles after start; a=0x13, b=0x12 -> f=10 at 9 cycles; a=0x12, b=0x13 -> f=01 at 9 cycles.
REQ-032 start a=0x01, b=0x02, pulse start again at cycle +3 with a=0xFF -> single done, f=01, second start ignored.
REQ-033 start a=b=0x00, assert rst at cycle +4 -> no done, f=00, busy=0; new start afterwards runs normally.
REQ-034 WIDTH=16, DIGIT=4, a=0x1234, b=0x1235, sgn=0 -> f=01, done 5 cycles after start; back-to-back start in DONE cycle accepted.
